decode_writeback: RTL and testbench
===================================

DECODE_WRITEBACK -- requirements
Module: decode_writeback

Interface
REQ-001 clk  in  1  single clock; all state updates on the rising edge.
REQ-002 rst  in  1  reset, asynchronous and active-high.
REQ-003 D_stat  in  [0:3]  decode status, one-hot: AOK=1000, HLT=0100, ADR=0010, INS=0001.
REQ-004 D_icode, D_ifun  in  4 each  decode instruction code and function.
REQ-005 D_rA, D_rB  in  4 each  register specifiers; 0xF means RNONE.
REQ-006 D_valC, D_valP  in  64 each  constant word and next PC.
REQ-007 E_bubble  in  1  load a bubble into the E register at the next edge.
REQ-008 e_dstE, M_dstE, M_dstM, W_dstE, W_dstM  in  4 each  downstream destinations for forwarding and writeback.
REQ-009 e_valE, M_valE, m_valM, W_valE, W_valM  in  64 each  downstream values for forwarding and writeback.
REQ-010 W_icode  in  4  writeback-stage instruction code.
REQ-011 d_srcA, d_srcB  out  4 each  combinational decode source IDs.
REQ-012 E_stat [0:3], E_icode 4, E_ifun 4  out  E pipeline register fields.
REQ-013 E_valC, E_valA, E_valB  out  64 each  E pipeline register data.
REQ-014 E_dstE, E_dstM, E_srcA, E_srcB  out  4 each  E pipeline register IDs.
REQ-015 regis0..regis14  out  64 each  live register-file contents; index 4 is %rsp.

Function
REQ-016 Register file SHALL have 15 x 64-bit entries; ID 0xF reads as 0 and is never written.
REQ-017 d_srcA SHALL be rA for icode 2/4/6/A, 4 for icode 9/B, and 0xF otherwise.
REQ-018 d_srcB SHALL be rB for icode 4/5/6, 4 for icode 8/9/A/B, and 0xF otherwise.
REQ-019 d_dstE SHALL be rB for icode 2/3/6, 4 for icode 8/9/A/B, and 0xF otherwise.
REQ-020 d_dstM SHALL be rA for icode 5/B and 0xF otherwise.
REQ-021 d_valA priority: icode 7 or 8 gives D_valP; else e_dstE gives e_valE; then M_dstM gives m_valM; then M_dstE gives M_valE; then W_dstM gives W_valM; then W_dstE gives W_valE; else the register file.
REQ-022 A forwarding source SHALL match only when its ID equals the src and the src is not 0xF.
REQ-023 d_valB SHALL use the same priority chain on d_srcB, without the valP case.
REQ-024 Writeback at a rising edge, only when W_icode is not 0 or 1: write W_valE to W_dstE if it is not 0xF; write W_valM to W_dstM if it is not 0xF.
REQ-025 If W_dstE equals W_dstM, the W_valM write SHALL win.
REQ-026 Written values SHALL appear on regis* after the edge; same-cycle reads SHALL rely on forwarding.
REQ-027 E register at a rising edge: if E_bubble, load a bubble; else load D_stat, D_icode, D_ifun, D_valC, d_valA, d_valB, d_dstE, d_dstM, d_srcA, d_srcB.
REQ-028 Bubble: stat=1000, icode=1, ifun=0, valC/valA/valB=0, dst and src fields=0xF.
REQ-029 Latency: one cycle from the D inputs to the E outputs; the decode outputs are combinational.

Reset
REQ-030 While rst=1: all 15 registers SHALL be 0 and the E register SHALL hold the bubble, asynchronously, regardless of clk.
REQ-031 Reset SHALL override E_bubble and writeback; normal operation resumes at the first rising edge after rst falls.

Verification
REQ-032 Reset mid-run: outputs -> regis*=0, E_icode=1, E_dstE=0xF immediately.
REQ-033 Write then decode: W_icode=3, W_dstE=2, W_valE=10, edge; then D_icode=6, rA=2, rB=3, no forwarding -> regis2=10, d_srcA=2, E_valA=10 after the next edge.
REQ-034 Forwarding priority: e_dstE=3 with e_valE=5 and M_dstE=3 with M_valE=7, D_icode=6, rB=3 -> E_valB=5; with e_dstE=0xF -> E_valB=7.
REQ-035 Call/ret: D_icode=8 with D_valP=0x40 -> E_valA=0x40, E_dstE=4, E_srcB=4; D_icode=9 -> d_srcA=4 and d_srcB=4.
REQ-036 Bubble: E_bubble=1 with D_icode=6 -> E_icode=1, E_stat=1000, E_dstE=0xF.
REQ-037 popq %rsp collision: W_dstE=4 with W_valE=8 and W_dstM=4 with W_valM=0x99, W_icode=B -> regis4=0x99.

Source files
------------

// File: rtl/decode_writeback.sv
// Decode stage with a 15-entry register file, operand forwarding and the E pipeline register.
// Writeback and E-register load share the rising edge; reset clears both asynchronously.
module decode_writeback (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:3]  D_stat,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  D_ifun,
  input  logic [3:0]  D_rA,
  input  logic [3:0]  D_rB,
  input  logic [63:0] D_valC,
  input  logic [63:0] D_valP,
  input  logic        E_bubble,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic [3:0]  W_dstE,
  input  logic [3:0]  W_dstM,
  input  logic [63:0] e_valE,
  input  logic [63:0] M_valE,
  input  logic [63:0] m_valM,
  input  logic [63:0] W_valE,
  input  logic [63:0] W_valM,
  input  logic [3:0]  W_icode,
  output logic [3:0]  d_srcA,
  output logic [3:0]  d_srcB,
  output logic [0:3]  E_stat,
  output logic [3:0]  E_icode,
  output logic [3:0]  E_ifun,
  output logic [63:0] E_valC,
  output logic [63:0] E_valA,
  output logic [63:0] E_valB,
  output logic [3:0]  E_dstE,
  output logic [3:0]  E_dstM,
  output logic [3:0]  E_srcA,
  output logic [3:0]  E_srcB,
  output logic [63:0] regis0,
  output logic [63:0] regis1,
  output logic [63:0] regis2,
  output logic [63:0] regis3,
  output logic [63:0] regis4,
  output logic [63:0] regis5,
  output logic [63:0] regis6,
  output logic [63:0] regis7,
  output logic [63:0] regis8,
  output logic [63:0] regis9,
  output logic [63:0] regis10,
  output logic [63:0] regis11,
  output logic [63:0] regis12,
  output logic [63:0] regis13,
  output logic [63:0] regis14
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  typedef struct packed {
    logic [0:3]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valC;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
  } ereg_t;

  localparam ereg_t BUBBLE = '{
    stat: 4'b1000, icode: 4'h1, ifun: 4'h0,
    valC: 64'd0, valA: 64'd0, valB: 64'd0,
    dstE: RNONE, dstM: RNONE, srcA: RNONE, srcB: RNONE
  };

  logic [63:0] rf_q [15];
  logic [63:0] rf_d [15];
  logic [63:0] rf_a;
  logic [63:0] rf_b;
  logic [3:0]  d_dstE;
  logic [3:0]  d_dstM;
  logic [63:0] d_valA;
  logic [63:0] d_valB;
  logic        wb_en;
  ereg_t       e_q;
  ereg_t       e_d;

  // Register specifier selection by instruction class.
  always_comb begin
    case (D_icode)
      4'h2, 4'h4, 4'h6, 4'hA: d_srcA = D_rA;
      4'h9, 4'hB:             d_srcA = RRSP;
      default:                d_srcA = RNONE;
    endcase
    case (D_icode)
      4'h4, 4'h5, 4'h6:       d_srcB = D_rB;
      4'h8, 4'h9, 4'hA, 4'hB: d_srcB = RRSP;
      default:                d_srcB = RNONE;
    endcase
    case (D_icode)
      4'h2, 4'h3, 4'h6:       d_dstE = D_rB;
      4'h8, 4'h9, 4'hA, 4'hB: d_dstE = RRSP;
      default:                d_dstE = RNONE;
    endcase
    case (D_icode)
      4'h5, 4'hB: d_dstM = D_rA;
      default:    d_dstM = RNONE;
    endcase
  end

  always_comb begin
    rf_a = 64'd0;
    rf_b = 64'd0;
    for (int i = 0; i < 15; i++) begin
      if (d_srcA == 4'(i)) rf_a = rf_q[i];
      if (d_srcB == 4'(i)) rf_b = rf_q[i];
    end
  end

  // Youngest producer wins; RNONE never matches a forwarding source.
  always_comb begin
    if (D_icode == 4'h7 || D_icode == 4'h8)         d_valA = D_valP;
    else if (d_srcA != RNONE && d_srcA == e_dstE)   d_valA = e_valE;
    else if (d_srcA != RNONE && d_srcA == M_dstM)   d_valA = m_valM;
    else if (d_srcA != RNONE && d_srcA == M_dstE)   d_valA = M_valE;
    else if (d_srcA != RNONE && d_srcA == W_dstM)   d_valA = W_valM;
    else if (d_srcA != RNONE && d_srcA == W_dstE)   d_valA = W_valE;
    else                                            d_valA = rf_a;

    if (d_srcB != RNONE && d_srcB == e_dstE)        d_valB = e_valE;
    else if (d_srcB != RNONE && d_srcB == M_dstM)   d_valB = m_valM;
    else if (d_srcB != RNONE && d_srcB == M_dstE)   d_valB = M_valE;
    else if (d_srcB != RNONE && d_srcB == W_dstM)   d_valB = W_valM;
    else if (d_srcB != RNONE && d_srcB == W_dstE)   d_valB = W_valE;
    else                                            d_valB = rf_b;
  end

  // W_valM is applied after W_valE so it wins when both target the same register.
  assign wb_en = (W_icode != 4'h0) && (W_icode != 4'h1);

  always_comb begin
    for (int i = 0; i < 15; i++) begin
      rf_d[i] = rf_q[i];
      if (wb_en && W_dstE == 4'(i)) rf_d[i] = W_valE;
      if (wb_en && W_dstM == 4'(i)) rf_d[i] = W_valM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) rf_q[i] <= 64'd0;
    end else begin
      for (int i = 0; i < 15; i++) rf_q[i] <= rf_d[i];
    end
  end

  always_comb begin
    if (E_bubble) begin
      e_d = BUBBLE;
    end else begin
      e_d.stat  = D_stat;
      e_d.icode = D_icode;
      e_d.ifun  = D_ifun;
      e_d.valC  = D_valC;
      e_d.valA  = d_valA;
      e_d.valB  = d_valB;
      e_d.dstE  = d_dstE;
      e_d.dstM  = d_dstM;
      e_d.srcA  = d_srcA;
      e_d.srcB  = d_srcB;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) e_q <= BUBBLE;
    else     e_q <= e_d;
  end

  assign E_stat  = e_q.stat;
  assign E_icode = e_q.icode;
  assign E_ifun  = e_q.ifun;
  assign E_valC  = e_q.valC;
  assign E_valA  = e_q.valA;
  assign E_valB  = e_q.valB;
  assign E_dstE  = e_q.dstE;
  assign E_dstM  = e_q.dstM;
  assign E_srcA  = e_q.srcA;
  assign E_srcB  = e_q.srcB;

  assign regis0  = rf_q[0];
  assign regis1  = rf_q[1];
  assign regis2  = rf_q[2];
  assign regis3  = rf_q[3];
  assign regis4  = rf_q[4];
  assign regis5  = rf_q[5];
  assign regis6  = rf_q[6];
  assign regis7  = rf_q[7];
  assign regis8  = rf_q[8];
  assign regis9  = rf_q[9];
  assign regis10 = rf_q[10];
  assign regis11 = rf_q[11];
  assign regis12 = rf_q[12];
  assign regis13 = rf_q[13];
  assign regis14 = rf_q[14];

endmodule

// File: tb/tb_decode_writeback.sv
// Bench for decode_writeback: directed scenarios plus random traffic against a
// table-driven reference of decode, forwarding and writeback.
module tb_decode_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:3]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic        E_bubble;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM, W_icode;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0]  d_srcA, d_srcB;
  logic [0:3]  E_stat;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] E_valC, E_valA, E_valB;
  logic [63:0] regis [15];

  int checks = 0;
  int errors = 0;
  logic [63:0] ref_rf [16];

  always #5 clk = ~clk;

  decode_writeback dut (
    .clk(clk), .rst(rst),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP), .E_bubble(E_bubble),
    .e_dstE(e_dstE), .M_dstE(M_dstE), .M_dstM(M_dstM), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .e_valE(e_valE), .M_valE(M_valE), .m_valM(m_valM), .W_valE(W_valE), .W_valM(W_valM),
    .W_icode(W_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
    .regis0(regis[0]), .regis1(regis[1]), .regis2(regis[2]), .regis3(regis[3]),
    .regis4(regis[4]), .regis5(regis[5]), .regis6(regis[6]), .regis7(regis[7]),
    .regis8(regis[8]), .regis9(regis[9]), .regis10(regis[10]), .regis11(regis[11]),
    .regis12(regis[12]), .regis13(regis[13]), .regis14(regis[14])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] ra);
    case (ic)
      4'h2, 4'h4, 4'h6, 4'hA: return ra;
      4'h9, 4'hB:             return 4'h4;
      default:                return 4'hF;
    endcase
  endfunction

  function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rb);
    case (ic)
      4'h4, 4'h5, 4'h6:       return rb;
      4'h8, 4'h9, 4'hA, 4'hB: return 4'h4;
      default:                return 4'hF;
    endcase
  endfunction

  function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic [3:0] rb);
    case (ic)
      4'h2, 4'h3, 4'h6:       return rb;
      4'h8, 4'h9, 4'hA, 4'hB: return 4'h4;
      default:                return 4'hF;
    endcase
  endfunction

  function automatic logic [3:0] m_dstM(input logic [3:0] ic, input logic [3:0] ra);
    return (ic == 4'h5 || ic == 4'hB) ? ra : 4'hF;
  endfunction

  // Operand value as the spec's priority list reads; ref_rf[15] stays 0 for RNONE.
  function automatic logic [63:0] m_operand(input logic [3:0] src, input bit use_valp);
    if (use_valp && (D_icode == 4'h7 || D_icode == 4'h8)) return D_valP;
    if (src != 4'hF) begin
      if (src == e_dstE) return e_valE;
      if (src == M_dstM) return m_valM;
      if (src == M_dstE) return M_valE;
      if (src == W_dstM) return W_valM;
      if (src == W_dstE) return W_valE;
    end
    return ref_rf[src];
  endfunction

  task automatic set_defaults();
    D_stat = 4'b1000; D_icode = 4'h1; D_ifun = 4'h0; D_rA = 4'hF; D_rB = 4'hF;
    D_valC = '0; D_valP = '0; E_bubble = 1'b0;
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
    e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0; W_icode = 4'h0;
  endtask

  task automatic check_regs();
    for (int i = 0; i < 15; i++) check($sformatf("regis%0d", i), regis[i], ref_rf[i]);
  endtask

  // One clock of traffic with the inputs already driven.
  task automatic step();
    logic [3:0]  sa, sb, de, dm, xic, xif;
    logic [63:0] va, vb, vc;
    logic [0:3]  xst;
    #1;
    sa = m_srcA(D_icode, D_rA);
    sb = m_srcB(D_icode, D_rB);
    check("d_srcA", 64'(d_srcA), 64'(sa));
    check("d_srcB", 64'(d_srcB), 64'(sb));
    if (E_bubble) begin
      xst = 4'b1000; xic = 4'h1; xif = 4'h0; vc = '0; va = '0; vb = '0;
      de = 4'hF; dm = 4'hF; sa = 4'hF; sb = 4'hF;
    end else begin
      xst = D_stat; xic = D_icode; xif = D_ifun; vc = D_valC;
      va = m_operand(sa, 1'b1);
      vb = m_operand(sb, 1'b0);
      de = m_dstE(D_icode, D_rB);
      dm = m_dstM(D_icode, D_rA);
    end
    @(posedge clk);
    #1;
    if (W_icode > 4'h1) begin
      if (W_dstE != 4'hF) ref_rf[W_dstE] = W_valE;
      if (W_dstM != 4'hF) ref_rf[W_dstM] = W_valM;
    end
    check("E_stat", 64'(E_stat), 64'(xst));
    check("E_icode", 64'(E_icode), 64'(xic));
    check("E_ifun", 64'(E_ifun), 64'(xif));
    check("E_valC", E_valC, vc);
    check("E_valA", E_valA, va);
    check("E_valB", E_valB, vb);
    check("E_dstE", 64'(E_dstE), 64'(de));
    check("E_dstM", 64'(E_dstM), 64'(dm));
    check("E_srcA", 64'(E_srcA), 64'(sa));
    check("E_srcB", 64'(E_srcB), 64'(sb));
    check_regs();
    @(negedge clk);
  endtask

  function automatic logic [3:0] rnd_id();
    int r;
    r = $urandom_range(0, 6);
    return (r == 6) ? 4'hF : 4'(r);
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) ref_rf[i] = '0;
    set_defaults();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_E_icode", 64'(E_icode), 64'h1);
    check("rst_E_stat", 64'(E_stat), 64'h8);
    check("rst_E_dstE", 64'(E_dstE), 64'hF);
    check("rst_E_srcA", 64'(E_srcA), 64'hF);
    check_regs();
    rst = 1'b0;

    // Write r2 = 10, then read it back through the register file.
    W_icode = 4'h3; W_dstE = 4'h2; W_valE = 64'd10;
    step();
    set_defaults();
    D_icode = 4'h6; D_rA = 4'h2; D_rB = 4'h3;
    step();
    check("wd_regis2", regis[2], 64'd10);
    check("wd_E_valA", E_valA, 64'd10);

    // Forwarding: execute stage beats memory stage.
    set_defaults();
    D_icode = 4'h6; D_rA = 4'h1; D_rB = 4'h3;
    e_dstE = 4'h3; e_valE = 64'd5; M_dstE = 4'h3; M_valE = 64'd7;
    step();
    check("fwd_e_valB", E_valB, 64'd5);
    e_dstE = 4'hF;
    step();
    check("fwd_m_valB", E_valB, 64'd7);

    // RNONE must not forward even when a stage also names RNONE.
    set_defaults();
    D_icode = 4'h6; D_rA = 4'hF; D_rB = 4'h3;
    e_dstE = 4'hF; e_valE = 64'hDEAD;
    step();
    check("rnone_E_valA", E_valA, 64'd0);

    // call / ret.
    set_defaults();
    D_icode = 4'h8; D_valP = 64'h40;
    step();
    check("call_E_valA", E_valA, 64'h40);
    check("call_E_dstE", 64'(E_dstE), 64'h4);
    check("call_E_srcB", 64'(E_srcB), 64'h4);
    D_icode = 4'h9;
    #1;
    check("ret_d_srcA", 64'(d_srcA), 64'h4);
    check("ret_d_srcB", 64'(d_srcB), 64'h4);
    step();

    // Bubble.
    set_defaults();
    E_bubble = 1'b1; D_icode = 4'h6; D_rA = 4'h1; D_rB = 4'h2;
    step();
    check("bub_E_icode", 64'(E_icode), 64'h1);
    check("bub_E_stat", 64'(E_stat), 64'h8);
    check("bub_E_dstE", 64'(E_dstE), 64'hF);

    // popq %rsp: memory value wins the register collision.
    set_defaults();
    W_icode = 4'hB; W_dstE = 4'h4; W_valE = 64'd8; W_dstM = 4'h4; W_valM = 64'h99;
    step();
    check("popq_regis4", regis[4], 64'h99);

    // No writeback for icode 0/1.
    set_defaults();
    W_icode = 4'h1; W_dstE = 4'h5; W_valE = 64'h55;
    step();
    check("nowb_regis5", regis[5], 64'd0);

    // Random traffic.
    for (int n = 0; n < 250; n++) begin
      D_stat   = 4'b1000 >> $urandom_range(0, 3);
      D_icode  = 4'($urandom_range(0, 15));
      D_ifun   = 4'($urandom_range(0, 15));
      D_rA     = rnd_id();
      D_rB     = rnd_id();
      D_valC   = {$urandom, $urandom};
      D_valP   = {$urandom, $urandom};
      E_bubble = ($urandom_range(0, 7) == 0);
      e_dstE   = rnd_id(); e_valE = {$urandom, $urandom};
      M_dstE   = rnd_id(); M_valE = {$urandom, $urandom};
      M_dstM   = rnd_id(); m_valM = {$urandom, $urandom};
      W_dstE   = rnd_id(); W_valE = {$urandom, $urandom};
      W_dstM   = rnd_id(); W_valM = {$urandom, $urandom};
      W_icode  = 4'($urandom_range(0, 11));
      step();
    end

    // Asynchronous reset mid-run, then a clock edge while still in reset.
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 15; i++) ref_rf[i] = '0;
    check("amid_E_icode", 64'(E_icode), 64'h1);
    check("amid_E_dstE", 64'(E_dstE), 64'hF);
    check_regs();
    set_defaults();
    W_icode = 4'h3; W_dstE = 4'h2; W_valE = 64'h77; E_bubble = 1'b0; D_icode = 4'h6;
    @(posedge clk);
    #1;
    check("rstedge_regis2", regis[2], 64'd0);
    check("rstedge_E_icode", 64'(E_icode), 64'h1);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("post_rst_regis2", regis[2], 64'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
